uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receive channel: serial rx line in, framed data word out on a
//  valid/ready handshake. Data width, parity mode and stop-bit count are parameters.
//  Adds an input synchroniser, false-start rejection, parity/framing error flags and
//  overrun detection. Sits between the board rx pin and a byte consumer or RX FIFO.
// PARAMETERS
//  CLKS_PER_BIT  217  clk cycles per bit = f_clk / baud; legal range 4..65535
//  DATA_BITS     8    data bits per frame, 5..9, LSB first on the line
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous, active-low reset
//  rx          in   1          async serial line, idle high
//  rx_data     out  DATA_BITS  received word, valid while rx_valid = 1
//  rx_valid    out  1          word available
//  rx_ready    in   1          consumer accepts the word when rx_valid & rx_ready
//  parity_err  out  1          parity mismatch for the held word (0 when PARITY = 0)
//  frame_err   out  1          a stop-bit sample was 0 for the held word
//  overrun     out  1          sticky: at least one frame was dropped while rx_valid was held
//  busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; synchroniser flops = 1; FSM = IDLE; counters = 0.
//  - rx passes through a 2-FF synchroniser (rx_s); all logic uses rx_s only.
//  - Bit counter width is $clog2(CLKS_PER_BIT); index counter width is $clog2(DATA_BITS+1).
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   leave on a 1->0 edge of rx_s -> START with cnt = 0. A line already low at
//            reset or after a frame does not start a new frame until it returns high.
//    START:  at cnt = (CLKS_PER_BIT-1)/2, re-sample. If rx_s = 1, it is a false start:
//            return to IDLE, no output. Otherwise cnt = 0 -> DATA.
//            All later samples are taken at cnt = CLKS_PER_BIT-1, i.e. mid-bit.
//    DATA:   shift in DATA_BITS samples LSB first -> PARITY if PARITY != 0, else -> STOP.
//    PARITY: one sample; err = (XOR of data ^ sample) != (PARITY == 1) -> STOP.
//    STOP:   STOP_BITS samples; any 0 sets frame_err. After the last stop sample, return
//            to IDLE immediately. The remaining half bit is not waited out.
//  - Completion: on the cycle after the last stop sample, the word and flags are loaded and
//    rx_valid = 1. Line to rx_valid latency = 2 sync cycles + half-bit + (frame bits-1) bits.
//  - Handshake: rx_data and the flags hold stable while rx_valid = 1 & !rx_ready.
//    When rx_valid & rx_ready: rx_valid clears next cycle, and overrun clears.
//  - Completion while rx_valid = 1 and no handshake that cycle: the new frame is discarded,
//    the old word is kept, and overrun is set.
//  - Completion in the same cycle as a handshake: the new word loads, rx_valid stays 1,
//    and overrun is not set.
//  - Frames with errors are still delivered, with the error flag set.
//  - rst_n asserted mid-frame: immediate abort to reset values. The partial frame is lost.
//    After release, the FSM waits for the next falling edge.
// TESTING  (CLKS_PER_BIT = 16 unless stated)
//  1. 8N1, send 0xA5, rx_ready = 1 -> one rx_valid pulse, rx_data = 0xA5, all flags 0.
//  2. 8E1, send 0x07 with parity bit 0 -> rx_data = 0x07, parity_err = 1.
//     Send the same word with parity bit 1 -> parity_err = 0.
//  3. 8N2, second stop bit driven 0, data 0x3C -> rx_data = 0x3C, frame_err = 1.
//     The next frame 0x55 is received clean.
//  4. rx low glitch of 5 clocks -> busy pulses, rx_valid never asserts, then 0x81 received correctly.
//  5. rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun = 1.
//     Raise rx_ready -> 0x11 accepted, overrun = 0, no 0x22 delivered.
//  6. DATA_BITS = 7, PARITY = 1, 0x7F at CLKS_PER_BIT = 217.
//     Assert rst_n low at data bit 3 -> outputs 0 at once. After release, 0x7F is received intact.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if -- receive-side handshake bundle between the UART receiver and its consumer.
//   rx_data    : received word, valid while rx_valid = 1
//   rx_valid   : word available
//   rx_ready   : consumer accepts the word when rx_valid & rx_ready
//   parity_err : parity mismatch for the held word
//   frame_err  : a stop-bit sample was 0 for the held word
//   overrun    : sticky, a frame was dropped while rx_valid was held
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receive channel.
// Samples an asynchronous, idle-high serial line through a 2-FF synchroniser,
// rejects false starts, deframes DATA_BITS data bits (LSB first), an optional
// parity bit and STOP_BITS stop bits, and presents the word with parity/framing
// flags on a valid/ready handshake. A frame completing while the previous word
// is still held is dropped and flagged as overrun.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous, active-low reset
//   rx    : asynchronous serial line, idle high
//   busy  : receiver FSM not in IDLE
//   bus   : uart_rx_if master (rx_data, rx_valid, rx_ready, parity_err,
//           frame_err, overrun)
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,  // f_clk / baud, 4..65535
  parameter int DATA_BITS    = 8,    // 5..9
  parameter int PARITY       = 0,    // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  output logic     busy,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);

  // Value the XOR of data and parity bit must take for a clean frame.
  localparam logic PARITY_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Synchroniser and line history
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_prev_q, rx_prev_d;
  logic rx_s;

  // Deframing state
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;

  // Output holding registers
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic cnt_tick;
  logic done;
  logic handshake;

  assign rx_s      = sync2_q;
  assign cnt_tick  = (cnt_q == CNT_LAST);
  assign handshake = valid_q & bus.rx_ready;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_prev_d  = rx_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // rx_prev_q resets to 0, so a line held low through reset or left low
        // by a bad stop bit must first be seen high before a start is taken.
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;  // glitch shorter than half a bit
          end else begin
            state_d    = S_DATA;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_tick) begin
          cnt_d   = '0;
          // LSB arrives first: shift in at the top so it ends at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_PARITY: begin
        if (cnt_tick) begin
          cnt_d      = '0;
          perr_acc_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_tick) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_acc_d = 1'b1;
          end
          if (idx_q == IDX_STOP_LAST) begin
            // Leave mid-bit so a back-to-back start edge is not missed.
            idx_d   = '0;
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output side: a handshake frees the holding register; a completing frame
  // either loads into a free (or just-freed) register or is dropped as overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (done) begin
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_q | ~rx_s;  // include the stop sample taken now
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg -- scoreboard bench for uart_rx_cfg.
// Four receivers with different configurations share clk/rst_n:
//   ch0 8N1 @16, ch1 8E1 @16, ch2 8N2 @16, ch3 7O1 @217.
// The stimulus side serialises frames bit by bit and pushes the word a
// consumer should see (data, flags) into a queue; a monitor pops on every
// handshake and compares. Only one channel is active at a time.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  function automatic int cfg_cpb(input int ch);
    return (ch == 3) ? 217 : 16;
  endfunction
  function automatic int cfg_db(input int ch);
    return (ch == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int ch);
    return (ch == 1) ? 2 : ((ch == 3) ? 1 : 0);
  endfunction
  function automatic int cfg_sb(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rx_line[4];
  logic       rdy[4];
  logic       busy_w[4];
  logic [8:0] m_data[4];
  logic       m_valid[4];
  logic       m_perr[4];
  logic       m_ferr[4];
  logic       m_ovr[4];

  for (genvar g = 0; g < 4; g++) begin : chan
    localparam int DB = cfg_db(g);
    uart_rx_if #(.DATA_BITS(DB)) bus ();
    uart_rx_cfg #(
      .CLKS_PER_BIT(cfg_cpb(g)),
      .DATA_BITS   (DB),
      .PARITY      (cfg_par(g)),
      .STOP_BITS   (cfg_sb(g))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rx_line[g]),
      .busy (busy_w[g]),
      .bus  (bus)
    );
    assign bus.rx_ready = rdy[g];
    assign m_data[g]    = 9'(bus.rx_data);
    assign m_valid[g]   = bus.rx_valid;
    assign m_perr[g]    = bus.parity_err;
    assign m_ferr[g]    = bus.frame_err;
    assign m_ovr[g]     = bus.overrun;
  end

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  logic exp_ovr[4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pops one expectation per handshake seen on any channel.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (rst_n && m_valid[g] && rdy[g]) begin
          if (exp_q.size() == 0 || exp_q[0].ch != g) begin
            n_vec++;
            n_err++;
            $display("FAIL ch%0d spurious word: actual data=%0h, required no word", g, m_data[g]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("ch%0d data", g), 32'(m_data[g]), 32'(e.data));
            check($sformatf("ch%0d parity_err", g), 32'(m_perr[g]), 32'(e.perr));
            check($sformatf("ch%0d frame_err", g), 32'(m_ferr[g]), 32'(e.ferr));
            check($sformatf("ch%0d overrun", g), 32'(m_ovr[g]), 32'(exp_ovr[g]));
            exp_ovr[g] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic drive_bit(input int ch, input logic v, input int n);
    rx_line[ch] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ch, input int n);
    drive_bit(ch, 1'b1, n);
  endtask

  // Reference model: what the consumer must see for this frame, decided from
  // the bits on the line and whether an undelivered word is still held.
  task automatic model(input int ch, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops);
    exp_t e;
    int   ones = 0;
    int   pending = 0;
    logic good_p;
    e.ch   = ch;
    e.data = '0;
    for (int i = 0; i < cfg_db(ch); i++) begin
      e.data[i] = data[i];
      ones += int'(data[i]);
    end
    good_p = (cfg_par(ch) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    e.perr = (cfg_par(ch) != 0) && (pbit != good_p);
    e.ferr = !stops[0] || (cfg_sb(ch) == 2 && !stops[1]);
    foreach (exp_q[i]) if (exp_q[i].ch == ch) pending++;
    if (!rdy[ch] && pending > 0) exp_ovr[ch] = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    int cpb = cfg_cpb(ch);
    model(ch, data, pbit, stops);
    drive_bit(ch, 1'b0, cpb);
    for (int i = 0; i < cfg_db(ch); i++) drive_bit(ch, data[i], cpb);
    if (cfg_par(ch) != 0) drive_bit(ch, pbit, cpb);
    for (int i = 0; i < cfg_sb(ch); i++) drive_bit(ch, stops[i], cpb);
    rx_line[ch] = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_busy, saw_valid;
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      rx_line[g] = 1'b1;
      rdy[g]     = 1'b1;
      exp_ovr[g] = 1'b0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset ch%0d valid", g), 32'(m_valid[g]), 32'd0);
      check($sformatf("reset ch%0d data", g), 32'(m_data[g]), 32'd0);
      check($sformatf("reset ch%0d flags", g), 32'({m_perr[g], m_ferr[g], m_ovr[g]}), 32'd0);
      check($sformatf("reset ch%0d busy", g), 32'(busy_w[g]), 32'd0);
    end
    rst_n = 1'b1;
    idle(0, 5);

    // 8N1 basic word
    send_frame(0, 9'hA5, 1'b0, 2'b11);
    idle(0, 16);
    wait_drain("t1 drain", 200);

    // 8E1: wrong then right parity bit
    send_frame(1, 9'h07, 1'b0, 2'b11);
    idle(1, 16);
    send_frame(1, 9'h07, 1'b1, 2'b11);
    idle(1, 16);
    wait_drain("t2 drain", 200);

    // 8N2: second stop bit low, then a clean frame
    send_frame(2, 9'h3C, 1'b0, 2'b01);
    idle(2, 20);
    send_frame(2, 9'h55, 1'b0, 2'b11);
    idle(2, 16);
    wait_drain("t3 drain", 200);

    // 5-clock low glitch: busy pulses, no word
    drive_bit(0, 1'b0, 5);
    rx_line[0] = 1'b1;
    saw_busy  = 1'b0;
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_busy  |= busy_w[0];
      saw_valid |= m_valid[0];
    end
    check("glitch busy pulse", 32'(saw_busy), 32'd1);
    check("glitch no valid", 32'(saw_valid), 32'd0);
    check("glitch busy back to idle", 32'(busy_w[0]), 32'd0);
    send_frame(0, 9'h81, 1'b0, 2'b11);
    idle(0, 16);
    wait_drain("t4 drain", 200);

    // Overrun: consumer stalled across two frames
    rdy[0] = 1'b0;
    send_frame(0, 9'h11, 1'b0, 2'b11);
    idle(0, 20);
    send_frame(0, 9'h22, 1'b0, 2'b11);
    idle(0, 20);
    check("ovr held valid", 32'(m_valid[0]), 32'd1);
    check("ovr held data", 32'(m_data[0]), 32'h11);
    check("ovr flag set", 32'(m_ovr[0]), 32'd1);
    rdy[0] = 1'b1;
    wait_drain("t5 drain", 50);
    check("ovr valid cleared", 32'(m_valid[0]), 32'd0);
    check("ovr flag cleared", 32'(m_ovr[0]), 32'd0);
    idle(0, 40);

    // 7O1 @217: reset in the middle of data bit 3, then a full frame
    drive_bit(3, 1'b0, 217);
    for (int i = 0; i < 3; i++) drive_bit(3, 1'b1, 217);
    drive_bit(3, 1'b1, 108);
    check("t6 busy before reset", 32'(busy_w[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 busy in reset", 32'(busy_w[3]), 32'd0);
    check("t6 valid in reset", 32'(m_valid[3]), 32'd0);
    check("t6 flags in reset", 32'({m_perr[3], m_ferr[3], m_ovr[3]}), 32'd0);
    rx_line[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3, 10);
    send_frame(3, 9'h7F, 1'b0, 2'b11);
    idle(3, 217);
    wait_drain("t6 drain", 1000);

    // Randomised frames, random parity bits and occasional bad stop bits
    for (int k = 0; k < 40; k++) begin
      int         ch;
      logic [8:0] d;
      logic       p;
      logic [1:0] st;
      ch = (k % 10 == 9) ? 3 : int'($urandom_range(0, 2));
      d  = 9'($urandom);
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(ch, d, p, st);
      idle(ch, int'($urandom_range(4, 40)));
    end
    idle(0, 300);
    wait_drain("random drain", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
